// File: rtl/cpu_loader.sv
// cpu_loader: byte-stream boot loader filling cpu imem/dmem and gating cpu enable (optional CPU_LOADER_CHECKSUM_EN adds a trailing XOR byte)
module cpu_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int ADDR_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        load_done,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2;
`ifdef CPU_LOADER_CHECKSUM_EN
  localparam logic [1:0] CSUM = 2'd3;
  logic [7:0] csum_q, csum_d;
`endif
  logic [1:0] state_q, state_d, bcnt_q, bcnt_d;
  logic [7:0] lo_q, lo_d;
  logic [23:0] shr_q, shr_d;
  logic [31:0] idx_q, idx_d, idx_inc, depth, word;
  logic [15:0] rem_q, rem_d;
  logic [31:0] ia_q, ia_d, iw_q, iw_d, da_q, da_d, dw_q, dw_d;
  logic sel_q, sel_d, pend_q, pend_d, done_q, done_d, err_q, err_d, en_q, en_d;
  logic iwen_q, iwen_d, dwen_q, dwen_d, rdy_q, hs;
  assign hs = s_valid & rdy_q;
  assign depth = sel_q ? 32'(DMEM_WORDS) : 32'(IMEM_WORDS);
  assign idx_inc = (idx_q + 32'd1 == depth) ? '0 : idx_q + 32'd1;
  assign word = {s_data, shr_q};
  assign s_ready = rdy_q;
  assign imem_addr = ia_q;
  assign imem_wen = iwen_q;
  assign imem_wdata = iw_q;
  assign dmem_addr = da_q;
  assign dmem_wen = dwen_q;
  assign dmem_wdata = dw_q;
  assign cpu_enable = en_q;
  assign busy = state_q != IDLE;
  assign load_done = done_q;
  assign err = err_q;
  // next-state: command decode, header capture, word assembly and write strobes
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    lo_d = lo_q;
    shr_d = shr_q;
    idx_d = idx_q;
    rem_d = rem_q;
    sel_d = sel_q;
    err_d = err_q;
    en_d = en_q;
    ia_d = ia_q;
    iw_d = iw_q;
    da_d = da_q;
    dw_d = dw_q;
    iwen_d = 1'b0;
    dwen_d = 1'b0;
    pend_d = 1'b0;
    done_d = pend_q;
`ifdef CPU_LOADER_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (hs) begin
      case (state_q)
        IDLE: begin
          if (s_data == 8'h01 || s_data == 8'h02) begin
            if (en_q) err_d = 1'b1;
            else begin
              state_d = HDR;
              sel_d = s_data[1];
`ifdef CPU_LOADER_CHECKSUM_EN
              csum_d = '0;
`endif
            end
          end
          else if (s_data == 8'h03) en_d = 1'b1;
          else if (s_data == 8'h04) en_d = 1'b0;
          else if (s_data == 8'h00) err_d = 1'b0;
          else err_d = 1'b1;
        end
        HDR: begin
          bcnt_d = bcnt_q + 2'd1;
          lo_d = s_data;
          if (bcnt_q == 2'd1)
            idx_d = sel_q ? 32'({s_data, lo_q}) % 32'(DMEM_WORDS) : 32'({s_data, lo_q}) % 32'(IMEM_WORDS);
          if (bcnt_q == 2'd3) begin
            rem_d = {s_data, lo_q};
            if (rem_d != 16'd0) state_d = DATA;
            else begin
`ifdef CPU_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = IDLE;
              done_d = 1'b1;
`endif
            end
          end
        end
        DATA: begin
          bcnt_d = bcnt_q + 2'd1;
          shr_d = {s_data, shr_q[23:8]};
`ifdef CPU_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ s_data;
`endif
          if (bcnt_q == 2'd3) begin
            if (sel_q) begin
              da_d = idx_q << ADDR_SHIFT;
              dw_d = word;
              dwen_d = 1'b1;
            end
            else begin
              ia_d = idx_q << ADDR_SHIFT;
              iw_d = word;
              iwen_d = 1'b1;
            end
            idx_d = idx_inc;
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
`ifdef CPU_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = IDLE;
              pend_d = 1'b1;
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
`ifdef CPU_LOADER_CHECKSUM_EN
          done_d = s_data == csum_q;
          err_d = err_q | (s_data != csum_q);
`endif
        end
      endcase
    end
  end
  // state registers; reset clears everything and drops any pending strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      lo_q <= '0;
      shr_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
      sel_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      en_q <= 1'b0;
      rdy_q <= 1'b0;
      ia_q <= '0;
      iw_q <= '0;
      da_q <= '0;
      dw_q <= '0;
      iwen_q <= 1'b0;
      dwen_q <= 1'b0;
`ifdef CPU_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end
    else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      lo_q <= lo_d;
      shr_q <= shr_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      sel_q <= sel_d;
      pend_q <= pend_d;
      done_q <= done_d;
      err_q <= err_d;
      en_q <= en_d;
      rdy_q <= 1'b1;
      ia_q <= ia_d;
      iw_q <= iw_d;
      da_q <= da_d;
      dw_q <= dw_d;
      iwen_q <= iwen_d;
      dwen_q <= dwen_d;
`ifdef CPU_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_loader.sv
// tb_cpu_loader: self-checking bench for cpu_loader with a write scoreboard and command table
module tb_cpu_loader;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_ready, imem_wen, dmem_wen, cpu_enable, busy, load_done, err;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  typedef struct {logic d; logic [31:0] a; logic [31:0] w;} wr_t;
  typedef struct {logic [7:0] cmd; logic en; logic er;} vec_t;
  wr_t sb[$];
  wr_t mon_e;
  vec_t vt[8];
  logic [31:0] wbuf[4];
  int compared = 0, mismatched = 0, cyc = 0, done_cnt = 0, exp_done = 0, last_wen_t = 0, last_done_t = 0;

  cpu_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .cpu_enable(cpu_enable), .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (imem_wen && dmem_wen) chk("dual_wen", 32'd1, 32'd0);
    else if (imem_wen || dmem_wen) begin
      last_wen_t = cyc;
      if (sb.size() == 0) chk("unexpected_wen", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("wen_port", 32'(dmem_wen), 32'(mon_e.d));
        chk("waddr", dmem_wen ? dmem_addr : imem_addr, mon_e.a);
        chk("wdata", dmem_wen ? dmem_wdata : imem_wdata, mon_e.w);
      end
    end
    if (load_done) begin
      done_cnt++;
      last_done_t = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic r;
    int t = 0;
    s_valid = 1'b1;
    s_data = b;
    do begin
      r = s_ready;
      @(negedge clk);
      t++;
    end while (!r && t < 20);
    if (!r) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int g;
    if (gaps) begin
      g = $urandom_range(0, 2);
      s_valid = 1'b0;
      repeat (g) begin
        s_data = 8'($urandom);
        @(negedge clk);
      end
    end
    send_byte(b);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] n, input bit gaps, input bit bad);
    logic [7:0] cs;
    logic [31:0] depth;
    cs = 8'h00;
    depth = (cmd == 8'h02) ? 32'd1024 : 32'd512;
    send(cmd, gaps);
    send(s[7:0], gaps);
    send(s[15:8], gaps);
    send(n[7:0], gaps);
    send(n[15:8], gaps);
    for (int i = 0; i < int'(n); i++) begin
      sb.push_back('{cmd == 8'h02, ((32'(s) + 32'(i)) % depth) << 2, wbuf[i]});
      for (int b = 0; b < 4; b++) begin
        send(wbuf[i][8*b +: 8], gaps);
        cs = cs ^ wbuf[i][8*b +: 8];
      end
    end
`ifdef CPU_LOADER_CHECKSUM_EN
    send(bad ? cs ^ 8'h01 : cs, gaps);
`endif
    if (!bad) exp_done++;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h03, 1'b1, 1'b0};
    vt[1] = '{8'h01, 1'b1, 1'b1};
    vt[2] = '{8'h04, 1'b0, 1'b1};
    vt[3] = '{8'h00, 1'b0, 1'b0};
    vt[4] = '{8'h07, 1'b0, 1'b1};
    vt[5] = '{8'h00, 1'b0, 1'b0};
    vt[6] = '{8'hFF, 1'b0, 1'b1};
    vt[7] = '{8'h00, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_flags", 32'({imem_wen, dmem_wen, cpu_enable, busy, load_done, err}), 32'd0);
    chk("rst_buses", imem_addr | imem_wdata | dmem_addr | dmem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_ready), 32'd1);

    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'h55667788;
    send_frame(8'h01, 16'd0, 16'd2, 1'b0, 1'b0);
    drain();
    chk("done_latency", 32'(last_done_t - last_wen_t), 32'd1);

    wbuf[0] = 32'hA5A5A5A5;
    wbuf[1] = 32'h5A5A5A5A;
    send_frame(8'h02, 16'd1023, 16'd2, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 8; i++) begin
      send_byte(vt[i].cmd);
      chk("cmd_en", 32'(cpu_enable), 32'(vt[i].en));
      chk("cmd_err", 32'(err), 32'(vt[i].er));
      chk("cmd_busy", 32'(busy), 32'd0);
    end
    drain();

    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h01234567;
    wbuf[2] = 32'hCAFEF00D;
    send_frame(8'h01, 16'h01FE, 16'd3, 1'b1, 1'b0);
    drain();

    send_frame(8'h02, 16'd5, 16'd0, 1'b0, 1'b0);
    drain();

    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("midrst_flags", 32'({s_ready, imem_wen, dmem_wen, cpu_enable, busy, load_done, err}), 32'd0);
    chk("midrst_buses", imem_addr | imem_wdata | dmem_addr | dmem_wdata, 32'd0);
    rst = 1'b0;
    wbuf[0] = 32'h0BADF00D;
    send_frame(8'h01, 16'd7, 16'd1, 1'b0, 1'b0);
    drain();

`ifdef CPU_LOADER_CHECKSUM_EN
    wbuf[0] = 32'h08040201;
    send_frame(8'h01, 16'd0, 16'd1, 1'b0, 1'b0);
    drain();
    chk("csum_ok_err", 32'(err), 32'd0);
    send_frame(8'h01, 16'd0, 16'd1, 1'b0, 1'b1);
    drain();
    chk("csum_bad_err", 32'(err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cpu_loader.md
Name: cpu_loader

Overview:
- Boot/debug loader upstream of the cpu top.
- Accepts a byte stream with a valid/ready handshake and decodes a small command protocol.
- Drives the cpu's external instruction-memory write port (addr_ext/wen_ext/wdata_ext) and data-memory write port (addr_ext_2/wen_ext_2/wdata_ext_2), plus the cpu enable input.
- Lets the testbench or host fill both memories, then start and stop execution.

Parameters:
- IMEM_WORDS, 512, instruction memory depth in words; word index wraps modulo this value.
- DMEM_WORDS, 1024, data memory depth in words; word index wraps modulo this value.
- ADDR_SHIFT, 2, left shift applied to the word index to form the byte address output.

Ports:
- clk  input  1  system clock, the single clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- s_valid  input  1  stream byte valid.
- s_ready  output  1  stream byte ready.
- s_data  input  8  stream byte.
- imem_addr  output  32  byte address to the cpu addr_ext input.
- imem_wen  output  1  to the cpu wen_ext input.
- imem_wdata  output  32  to the cpu wdata_ext input.
- dmem_addr  output  32  byte address to the cpu addr_ext_2 input.
- dmem_wen  output  1  to the cpu wen_ext_2 input.
- dmem_wdata  output  32  to the cpu wdata_ext_2 input.
- cpu_enable  output  1  to the cpu enable input.
- busy  output  1  high whenever the state is not IDLE.
- load_done  output  1  one-cycle pulse when a load frame completes.
- err  output  1  sticky protocol error flag.

Behaviour:
- Reset (rst high at a clk edge): every output is 0, s_ready is 0, state goes to IDLE, all counters are cleared. Reset mid-frame abandons the frame. A write strobe pending in the reset cycle is dropped.
- Handshake: a byte is consumed only on a clk edge with s_valid and s_ready both high. s_ready is 1 in every state after the first post-reset cycle. Bytes held with s_valid low are never consumed twice.
- IDLE: a consumed byte is a command.
  - 0x01 is LOAD_I, 0x02 is LOAD_D; both go to HDR.
  - 0x03 sets cpu_enable=1. 0x04 sets cpu_enable=0. 0x00 clears err. The state stays IDLE for these three.
  - LOAD_I or LOAD_D while cpu_enable=1: err<=1, the command is dropped, the state stays IDLE.
  - Any other value: err<=1, the byte is dropped.
- HDR: consumes exactly 4 bytes, little-endian.
  - Bytes 0-1: start word index S (16 bits). Bytes 2-3: word count N (16 bits).
  - After byte 3: if N==0, pulse load_done the next cycle and return to IDLE. Otherwise go to DATA.
- DATA: assembles each word from 4 bytes, little-endian (first byte is bits 7:0).
  - On the edge that consumes the 4th byte, register the write; the selected *_wen is high for exactly the following cycle.
  - *_addr = ((S+i) mod DEPTH) << ADDR_SHIFT, where i runs 0..N-1 and DEPTH is IMEM_WORDS or DMEM_WORDS.
  - *_wdata = the assembled word.
  - The unselected port keeps wen=0. Address and wdata hold their last value while wen is low.
  - The next byte may be consumed in the same cycle as the write strobe; this gives a sustained 1 byte/cycle throughput.
  - After word N-1 is written, pulse load_done in the cycle after the final wen and return to IDLE (or go to CSUM when that feature is built in).
- Latency: 4th byte handshake at edge k gives wen high during cycle k+1. load_done is high during cycle k+2.
- Arithmetic: the index is computed modulo DEPTH, so S+i past the depth wraps to 0. The 16-bit counters never overflow within one frame.
- The s_data value is ignored when s_valid is low.

Optional Feature:
- Macro: CPU_LOADER_CHECKSUM_EN.
- When defined, a LOAD frame carries one extra byte after the data: the XOR of all 4N data bytes (0x00 when N==0). A CSUM state consumes it.
  - Mismatch: err<=1 and load_done does not pulse. Writes already issued are not undone.
  - Match: load_done pulses in the cycle after the checksum byte is consumed.
- When undefined, there is no checksum byte and no CSUM state; load_done follows the last write as described under Behaviour.

Test Plan:
- Stream 01 00 00 02 00 | 44 33 22 11 | 88 77 66 55 back-to-back.
  - Required: imem_wen pulses twice, with addr 0x0 data 0x11223344 and then addr 0x4 data 0x55667788.
  - Required: load_done pulses once, one cycle after the second wen; dmem_wen stays 0.
- LOAD_D with S=1023, N=2, words A5A5A5A5 and 5A5A5A5A.
  - Required: dmem_addr is 0xFFC and then 0x000 (wrap); cpu memory readback via rdata_ext_2 matches both words.
- Send 03, then 01.
  - Required: cpu_enable=1; err=1; no imem_wen; state remains IDLE.
  - Then send 04 and 00: required cpu_enable=0 and err=0.
- Randomly toggle s_valid during a 3-word LOAD_I.
  - Required: the same 3 writes occur with the same addresses and data; no byte is consumed while s_valid=0.
- Assert rst after 2 data bytes of a frame.
  - Required: no wen and all outputs 0 on the following cycle.
  - Then send a fresh frame: required normal completion.
- With CPU_LOADER_CHECKSUM_EN: send 01 00 00 01 00 | 01 02 04 08 | 0F.
  - Required: one write and load_done pulses.
  - Repeat with checksum 0x0E: required err=1, write still issued, no load_done.
